// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and the MIPS-subset datapath.
// The datapath side is master: it supplies the instruction and the memory handshake.
interface multicycle_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic [31:0]      Instruction;
   logic             mem_ready;
   logic             pc_wr;
   logic             Branch;
   logic             Jump;
   logic             RegWr;
   logic             MemWr;
   logic             RegDst;
   logic             ALUSrc;
   logic             MemToReg;
   logic             Rtype;
   logic             Jal;
   logic             Rtype_J;
   logic             Rtype_L;
   logic             WrByte;
   logic [4:0]       ALUCtr;
   logic [1:0]       ExtOp;
   logic [1:0]       LoadByte;
   logic             illegal;
   logic [CNT_W-1:0] retired;
   logic [2:0]       state;

   modport master (
      output Instruction, mem_ready,
      input  pc_wr, Branch, Jump, RegWr, MemWr, RegDst, ALUSrc, MemToReg, Rtype, Jal,
             Rtype_J, Rtype_L, WrByte, ALUCtr, ExtOp, LoadByte, illegal, retired, state
   );

   modport slave (
      input  Instruction, mem_ready,
      output pc_wr, Branch, Jump, RegWr, MemWr, RegDst, ALUSrc, MemToReg, Rtype, Jal,
             Rtype_J, Rtype_L, WrByte, ALUCtr, ExtOp, LoadByte, illegal, retired, state
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset controller: IF/ID/EX/MEM/WB sequencer, instruction decode,
// state-gated strobes with a data-memory ready handshake, and a retired-instruction counter.
module multicycle_ctrl #(
   parameter int unsigned CNT_W    = 32,
   parameter bit          MEM_WAIT = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   multicycle_ctrl_if.slave  bus
);

   localparam int unsigned ALU_W = 5;
   localparam int unsigned ST_W  = 3;

   typedef enum logic [ST_W-1:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_e;

   // Instruction class selects the state sequence after EX.
   typedef enum logic [2:0] {
      C_NOP   = 3'd0,
      C_ALU   = 3'd1,
      C_LOAD  = 3'd2,
      C_STORE = 3'd3,
      C_BR    = 3'd4,
      C_JUMP  = 3'd5,
      C_LINK  = 3'd6
   } cls_e;

   typedef struct packed {
      cls_e             cls;
      logic             reg_dst;
      logic             alu_src;
      logic             mem_to_reg;
      logic             rtype;
      logic             jal;
      logic             rtype_j;
      logic             rtype_l;
      logic             wr_byte;
      logic [ALU_W-1:0] alu_ctr;
      logic [1:0]       ext_op;
      logic [1:0]       load_byte;
   } dec_t;

   localparam logic [ALU_W-1:0] ALU_ADDU = 5'd0;
   localparam logic [ALU_W-1:0] ALU_ADD  = 5'd1;
   localparam logic [ALU_W-1:0] ALU_SUBU = 5'd2;
   localparam logic [ALU_W-1:0] ALU_SUB  = 5'd3;
   localparam logic [ALU_W-1:0] ALU_AND  = 5'd4;
   localparam logic [ALU_W-1:0] ALU_OR   = 5'd5;
   localparam logic [ALU_W-1:0] ALU_XOR  = 5'd6;
   localparam logic [ALU_W-1:0] ALU_NOR  = 5'd7;
   localparam logic [ALU_W-1:0] ALU_SLT  = 5'd8;
   localparam logic [ALU_W-1:0] ALU_SLTU = 5'd9;
   localparam logic [ALU_W-1:0] ALU_SLL  = 5'd10;
   localparam logic [ALU_W-1:0] ALU_SRL  = 5'd11;
   localparam logic [ALU_W-1:0] ALU_SRA  = 5'd12;
   localparam logic [ALU_W-1:0] ALU_LUI  = 5'd13;

   state_e           state_q, state_d;
   dec_t             dec_q, dec_d, dec_c;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             legal_c;
   logic             mem_rdy_c;
   logic             last_c;
   logic             pc_wr_c;
   logic [5:0]       op_c, fn_c;
   logic [4:0]       rt_c;
   logic             unused_instr_c;

   assign op_c           = bus.Instruction[31:26];
   assign fn_c           = bus.Instruction[5:0];
   assign rt_c           = bus.Instruction[20:16];
   assign unused_instr_c = ^{bus.Instruction[25:21], bus.Instruction[15:6]};
   assign mem_rdy_c      = MEM_WAIT ? bus.mem_ready : 1'b1;

   // Instruction decode; anything undecodable collapses to an all-zero NOP.
   always_comb begin
      dec_c   = '0;
      legal_c = 1'b1;
      case (op_c)
         6'h00: begin
            dec_c.cls     = C_ALU;
            dec_c.rtype   = 1'b1;
            dec_c.reg_dst = 1'b1;
            case (fn_c)
               6'h21:   dec_c.alu_ctr = ALU_ADDU;
               6'h20:   dec_c.alu_ctr = ALU_ADD;
               6'h23:   dec_c.alu_ctr = ALU_SUBU;
               6'h22:   dec_c.alu_ctr = ALU_SUB;
               6'h24:   dec_c.alu_ctr = ALU_AND;
               6'h25:   dec_c.alu_ctr = ALU_OR;
               6'h26:   dec_c.alu_ctr = ALU_XOR;
               6'h27:   dec_c.alu_ctr = ALU_NOR;
               6'h2A:   dec_c.alu_ctr = ALU_SLT;
               6'h2B:   dec_c.alu_ctr = ALU_SLTU;
               6'h00:   dec_c.alu_ctr = ALU_SLL;
               6'h02:   dec_c.alu_ctr = ALU_SRL;
               6'h03:   dec_c.alu_ctr = ALU_SRA;
               6'h08: begin
                  dec_c.cls     = C_JUMP;
                  dec_c.rtype_j = 1'b1;
               end
               6'h09: begin
                  dec_c.cls     = C_LINK;
                  dec_c.rtype_j = 1'b1;
                  dec_c.rtype_l = 1'b1;
               end
               default: legal_c = 1'b0;
            endcase
         end
         6'h01: begin
            dec_c.cls     = C_BR;
            dec_c.alu_ctr = ALU_SLT;
            dec_c.ext_op  = 2'b01;
            legal_c       = (rt_c == 5'd0) || (rt_c == 5'd1);
         end
         6'h02: dec_c.cls = C_JUMP;
         6'h03: begin
            dec_c.cls = C_LINK;
            dec_c.jal = 1'b1;
         end
         6'h04, 6'h05: begin
            dec_c.cls     = C_BR;
            dec_c.alu_ctr = ALU_SUBU;
            dec_c.ext_op  = 2'b01;
         end
         6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
            dec_c.cls     = C_ALU;
            dec_c.alu_src = 1'b1;
            dec_c.ext_op  = 2'b01;
            case (op_c)
               6'h08:   dec_c.alu_ctr = ALU_ADD;
               6'h0A:   dec_c.alu_ctr = ALU_SLT;
               6'h0B:   dec_c.alu_ctr = ALU_SLTU;
               6'h0C: begin dec_c.alu_ctr = ALU_AND; dec_c.ext_op = 2'b00; end
               6'h0D: begin dec_c.alu_ctr = ALU_OR;  dec_c.ext_op = 2'b00; end
               6'h0E: begin dec_c.alu_ctr = ALU_XOR; dec_c.ext_op = 2'b00; end
               6'h0F: begin dec_c.alu_ctr = ALU_LUI; dec_c.ext_op = 2'b10; end
               default: dec_c.alu_ctr = ALU_ADDU;
            endcase
         end
         6'h20, 6'h23, 6'h24: begin
            dec_c.cls        = C_LOAD;
            dec_c.alu_src    = 1'b1;
            dec_c.ext_op     = 2'b01;
            dec_c.mem_to_reg = 1'b1;
            dec_c.load_byte  = (op_c == 6'h20) ? 2'b11 : (op_c == 6'h24) ? 2'b10 : 2'b00;
         end
         6'h28, 6'h2B: begin
            dec_c.cls     = C_STORE;
            dec_c.alu_src = 1'b1;
            dec_c.ext_op  = 2'b01;
            dec_c.wr_byte = (op_c == 6'h28);
         end
         default: legal_c = 1'b0;
      endcase
      if (!legal_c) dec_c = '0;
   end

   // Next state; decode registers load only on the ID->EX edge.
   always_comb begin
      state_d = state_q;
      dec_d   = dec_q;
      case (state_q)
         S_IF: state_d = S_ID;
         S_ID: begin
            state_d = S_EX;
            dec_d   = dec_c;
         end
         S_EX: begin
            case (dec_q.cls)
               C_ALU, C_LINK:   state_d = S_WB;
               C_LOAD, C_STORE: state_d = S_MEM;
               default:         state_d = S_IF;
            endcase
         end
         S_MEM: if (mem_rdy_c) state_d = (dec_q.cls == C_LOAD) ? S_WB : S_IF;
         S_WB:  state_d = S_IF;
         default: state_d = S_IF;
      endcase
   end

   // Final state of each sequence carries the PC update.
   always_comb begin
      last_c = 1'b0;
      case (state_q)
         S_EX:    last_c = dec_q.cls inside {C_NOP, C_BR, C_JUMP};
         S_MEM:   last_c = (dec_q.cls == C_STORE) && mem_rdy_c;
         S_WB:    last_c = 1'b1;
         default: last_c = 1'b0;
      endcase
   end

   assign pc_wr_c   = last_c && !rst;
   assign retired_d = retired_q + CNT_W'(pc_wr_c);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IF;
         dec_q     <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         dec_q     <= dec_d;
         retired_q <= retired_d;
      end
   end

   // Strobes follow the same-cycle handshake and reset, so they are combinational.
   assign bus.pc_wr    = pc_wr_c;
   assign bus.Branch   = pc_wr_c && (dec_q.cls == C_BR);
   assign bus.Jump     = pc_wr_c && (dec_q.cls inside {C_JUMP, C_LINK});
   assign bus.RegWr    = (state_q == S_WB) && !rst;
   assign bus.MemWr    = (state_q == S_MEM) && (dec_q.cls == C_STORE) && mem_rdy_c && !rst;
   assign bus.illegal  = (state_q == S_ID) && !legal_c && !rst;

   assign bus.RegDst   = dec_q.reg_dst;
   assign bus.ALUSrc   = dec_q.alu_src;
   assign bus.MemToReg = dec_q.mem_to_reg;
   assign bus.Rtype    = dec_q.rtype;
   assign bus.Jal      = dec_q.jal;
   assign bus.Rtype_J  = dec_q.rtype_j;
   assign bus.Rtype_L  = dec_q.rtype_l;
   assign bus.WrByte   = dec_q.wr_byte;
   assign bus.ALUCtr   = dec_q.alu_ctr;
   assign bus.ExtOp    = dec_q.ext_op;
   assign bus.LoadByte = dec_q.load_byte;
   assign bus.retired  = retired_q;
   assign bus.state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: table of instructions with expected sequence length,
// strobe counts and steering, plus reset-during-MEM and 4-bit counter wrap sequences.
module tb_multicycle_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   multicycle_ctrl_if #(.CNT_W(32)) bus  ();
   multicycle_ctrl_if #(.CNT_W(4))  bus4 ();

   multicycle_ctrl #(.CNT_W(32), .MEM_WAIT(1'b1)) dut  (.clk(clk), .rst(rst), .bus(bus));
   multicycle_ctrl #(.CNT_W(4),  .MEM_WAIT(1'b1)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

   assign bus4.Instruction = bus.Instruction;
   assign bus4.mem_ready   = bus.mem_ready;

   typedef struct {
      string       name;
      logic [31:0] instr;
      int          lat;    // MEM cycles with mem_ready low before it rises
      int          len;    // cycles IF..last state inclusive
      int          n_rw;
      int          n_mw;
      int          n_br;
      int          n_j;
      int          n_ill;
      logic [7:0]  flags;  // RegDst ALUSrc MemToReg Rtype Jal Rtype_J Rtype_L WrByte
      logic [4:0]  alu;
      logic [1:0]  ext;
      logic [1:0]  lb;
   } vec_t;

   localparam int NV = 19;
   vec_t        vecs [NV];
   int          n_tests, n_fail, exp_ret;
   logic [16:0] prev_steer;

   function automatic logic [16:0] steer();
      return {bus.RegDst, bus.ALUSrc, bus.MemToReg, bus.Rtype, bus.Jal, bus.Rtype_J,
              bus.Rtype_L, bus.WrByte, bus.ALUCtr, bus.ExtOp, bus.LoadByte};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Entered at edge+1 of the IF cycle; leaves at edge+1 of the following IF cycle.
   task automatic run_vec(input vec_t v);
      int cyc, n_rw, n_mw, n_br, n_j, n_ill, mw_cyc, ill_cyc;
      bit done;
      logic [16:0] exp_st;
      exp_st = {v.flags, v.alu, v.ext, v.lb};
      bus.Instruction = v.instr;
      cyc = 0; done = 1'b0;
      n_rw = 0; n_mw = 0; n_br = 0; n_j = 0; n_ill = 0; mw_cyc = 0; ill_cyc = 0;
      while (!done && cyc < 30) begin
         cyc++;
         bus.mem_ready = (cyc >= 4 && cyc < 4 + v.lat) ? 1'b0 : 1'b1;
         #1;
         if (cyc == 2) check({v.name, "_id_hold"}, 32'(steer()), 32'(prev_steer));
         n_rw += int'(bus.RegWr);
         n_br += int'(bus.Branch);
         n_j  += int'(bus.Jump);
         if (bus.MemWr)   begin n_mw++;  mw_cyc  = cyc; end
         if (bus.illegal) begin n_ill++; ill_cyc = cyc; end
         if (bus.pc_wr) begin
            done = 1'b1;
            check({v.name, "_steer"}, 32'(steer()), 32'(exp_st));
         end
         step();
      end
      if (!done) begin
         n_tests++; n_fail++;
         $display("FAIL %s_timeout: no pc_wr within %0d cycles", v.name, cyc);
      end
      exp_ret++;
      check({v.name, "_cycles"},  32'(cyc),  32'(v.len));
      check({v.name, "_regwr"},   32'(n_rw), 32'(v.n_rw));
      check({v.name, "_memwr"},   32'(n_mw), 32'(v.n_mw));
      check({v.name, "_branch"},  32'(n_br), 32'(v.n_br));
      check({v.name, "_jump"},    32'(n_j),  32'(v.n_j));
      check({v.name, "_illegal"}, 32'(n_ill), 32'(v.n_ill));
      if (v.n_mw > 0) check({v.name, "_memwr_at_pcwr"}, 32'(mw_cyc), 32'(v.len));
      if (v.n_ill > 0) check({v.name, "_illegal_in_id"}, 32'(ill_cyc), 32'd2);
      check({v.name, "_retired"}, bus.retired, 32'(exp_ret));
      prev_steer = exp_st;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests = 0; n_fail = 0; exp_ret = 0; prev_steer = '0;
      //          name     instr         lat len rw mw br j ill flags         alu       ext    lb
      vecs[0]  = '{"addu",  32'h00221821, 0, 4, 1, 0, 0, 0, 0, 8'b1001_0000, 5'b00000, 2'b00, 2'b00};
      vecs[1]  = '{"sub",   32'h00A62022, 0, 4, 1, 0, 0, 0, 0, 8'b1001_0000, 5'b00011, 2'b00, 2'b00};
      vecs[2]  = '{"sra",   32'h00031103, 0, 4, 1, 0, 0, 0, 0, 8'b1001_0000, 5'b01100, 2'b00, 2'b00};
      vecs[3]  = '{"lw",    32'h8D280004, 3, 8, 1, 0, 0, 0, 0, 8'b0110_0000, 5'b00000, 2'b01, 2'b00};
      vecs[4]  = '{"lb",    32'h81280000, 0, 5, 1, 0, 0, 0, 0, 8'b0110_0000, 5'b00000, 2'b01, 2'b11};
      vecs[5]  = '{"lbu",   32'h91280000, 1, 6, 1, 0, 0, 0, 0, 8'b0110_0000, 5'b00000, 2'b01, 2'b10};
      vecs[6]  = '{"sb",    32'hA1280001, 0, 4, 0, 1, 0, 0, 0, 8'b0100_0001, 5'b00000, 2'b01, 2'b00};
      vecs[7]  = '{"sw",    32'hAD280008, 2, 6, 0, 1, 0, 0, 0, 8'b0100_0000, 5'b00000, 2'b01, 2'b00};
      vecs[8]  = '{"beq",   32'h10000003, 0, 3, 0, 0, 1, 0, 0, 8'b0000_0000, 5'b00010, 2'b01, 2'b00};
      vecs[9]  = '{"ori",   32'h346200FF, 0, 4, 1, 0, 0, 0, 0, 8'b0100_0000, 5'b00101, 2'b00, 2'b00};
      vecs[10] = '{"lui",   32'h3C021234, 0, 4, 1, 0, 0, 0, 0, 8'b0100_0000, 5'b01101, 2'b10, 2'b00};
      vecs[11] = '{"j",     32'h08000100, 0, 3, 0, 0, 0, 1, 0, 8'b0000_0000, 5'b00000, 2'b00, 2'b00};
      vecs[12] = '{"jal",   32'h0C000100, 0, 4, 1, 0, 0, 1, 0, 8'b0000_1000, 5'b00000, 2'b00, 2'b00};
      vecs[13] = '{"jr",    32'h03E00008, 0, 3, 0, 0, 0, 1, 0, 8'b1001_0100, 5'b00000, 2'b00, 2'b00};
      vecs[14] = '{"jalr",  32'h00A0F809, 0, 4, 1, 0, 0, 1, 0, 8'b1001_0110, 5'b00000, 2'b00, 2'b00};
      vecs[15] = '{"ill_op",32'hFC000000, 0, 3, 0, 0, 0, 0, 1, 8'b0000_0000, 5'b00000, 2'b00, 2'b00};
      vecs[16] = '{"bltz",  32'h0480FFFF, 0, 3, 0, 0, 1, 0, 0, 8'b0000_0000, 5'b01000, 2'b01, 2'b00};
      vecs[17] = '{"ill_fn",32'h0000003F, 0, 3, 0, 0, 0, 0, 1, 8'b0000_0000, 5'b00000, 2'b00, 2'b00};
      vecs[18] = '{"addi",  32'h20620005, 0, 4, 1, 0, 0, 0, 0, 8'b0100_0000, 5'b00001, 2'b01, 2'b00};

      rst = 1'b1;
      bus.Instruction = 32'h0;
      bus.mem_ready   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state",   32'(bus.state), 32'd0);
      check("reset_pc_wr",   32'(bus.pc_wr), 32'd0);
      check("reset_regwr",   32'(bus.RegWr), 32'd0);
      check("reset_retired", bus.retired,    32'd0);
      check("reset_steer",   32'(steer()),   32'd0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) run_vec(vecs[i]);

      // sw interrupted by reset while waiting in MEM
      bus.Instruction = 32'hAD280008;
      for (int c = 1; c <= 3; c++) begin
         bus.mem_ready = 1'b1;
         #1;
         step();
      end
      bus.mem_ready = 1'b0;
      #1;
      check("rstmem_in_mem", 32'(bus.state), 32'd3);
      step();
      rst = 1'b1;
      bus.mem_ready = 1'b1;
      #1;
      check("rstmem_memwr", 32'(bus.MemWr), 32'd0);
      check("rstmem_pc_wr", 32'(bus.pc_wr), 32'd0);
      step();
      check("rstmem_state_if", 32'(bus.state), 32'd0);
      check("rstmem_retired",  bus.retired,    32'd0);
      check("rstmem_steer",    32'(steer()),   32'd0);
      rst = 1'b0;
      exp_ret = 0;
      prev_steer = '0;

      // 4-bit counter wraps from 15 to 0
      for (int k = 0; k < 15; k++) run_vec(vecs[0]);
      check("wrap_cnt4_15", 32'(bus4.retired), 32'd15);
      run_vec(vecs[0]);
      check("wrap_cnt4_0",  32'(bus4.retired), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
